// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: UART receive FIFO controller over an external dual-port RAM.
// Optional occupancy output: define UART_FIFO_LEVEL_EN to add port level.
module uart_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  overflow,
  input  logic                  ovf_clr,
`ifdef UART_FIFO_LEVEL_EN
  output logic [AW:0]           level,
`endif
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ready,
  output logic                  ram_we,
  output logic [AW-1:0]         ram_addra,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [AW-1:0]         ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    VALID = 2'd2
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] stored;
  logic        has_data;
  logic        push;
  logic        drop;
  logic        pop;
  logic        fetch;
  logic        load;
  state_t      state;
  state_t      state_nx;

  // Occupancy of the RAM, from registered pointers only.
  assign stored   = wr_ptr - rd_ptr;
  assign has_data = (stored != '0);
  assign full     = (stored == FULL_CNT);

  // Write side: never stalled, dropped when RAM is full.
  assign push      = wr_en && !full;
  assign drop      = wr_en && full;
  assign ram_we    = push;
  assign ram_addra = wr_ptr[AW-1:0];
  assign ram_din   = wr_data;

  // Read side: RAM read address always follows the read pointer.
  assign ram_addrb = rd_ptr[AW-1:0];
  assign rd_valid  = (state == VALID);
  assign pop       = rd_valid && rd_ready;

`ifdef UART_FIFO_LEVEL_EN
  // Entries in RAM plus the one held in the output stage.
  assign level = stored + {{AW{1'b0}}, (state != EMPTY)};
`endif

  // Write pointer advances on every accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Read pointer advances when an entry is fetched from RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
    end else if (fetch) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky overflow; a dropped push wins over a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // Output register captures RAM data one cycle after the fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (load) begin
      rd_data <= ram_dout;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  // Read FSM next state and fetch/load strobes.
  always_comb begin
    state_nx = state;
    fetch    = 1'b0;
    load     = 1'b0;
    unique case (state)
      EMPTY: begin
        if (has_data) begin
          fetch    = 1'b1;
          state_nx = LOAD;
        end
      end
      LOAD: begin
        load     = 1'b1;
        state_nx = VALID;
      end
      VALID: begin
        if (pop) begin
          if (has_data) begin
            fetch    = 1'b1;
            state_nx = LOAD;
          end else begin
            state_nx = EMPTY;
          end
        end
      end
      default: begin
        state_nx = EMPTY;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl: directed bench for uart_fifo_ctrl with a behavioural
// dual-port RAM; define UART_FIFO_LEVEL_EN to also check level.
module tb_uart_fifo_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          full;
  logic          overflow;
  logic          ovf_clr = 1'b0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_ready = 1'b0;
  logic          ram_we;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_din;
  logic [AW-1:0] ram_addrb;
  logic [DW-1:0] ram_dout;
`ifdef UART_FIFO_LEVEL_EN
  logic [AW:0]   level;
  int            maxlvl;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] q [$];
  logic [DW-1:0] exp_b;

  int n;
  int prev;
  int pushed;
  int popped;
  int extra;

  uart_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
`ifdef UART_FIFO_LEVEL_EN
    .level     (level),
`endif
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .ram_we    (ram_we),
    .ram_addra (ram_addra),
    .ram_din   (ram_din),
    .ram_addrb (ram_addrb),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  // Dual-port RAM with registered read.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addra] <= ram_din;
    ram_dout <= mem[ram_addrb];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_full", full, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_we", ram_we, 0);
    check("rst_data", rd_data, 0);
`ifdef UART_FIFO_LEVEL_EN
    check("rst_level", level, 0);
`endif
    rst = 1'b0;

    // Single push 0xA5, visible in cycle 3
    tick();
    rd_ready = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hA5;
    #1;
    check("c0_we", ram_we, 1);
    check("c0_addra", ram_addra, 0);
    check("c0_din", ram_din, 8'hA5);
    check("c0_valid", rd_valid, 0);
    tick();
    wr_en = 1'b0;
    #1;
    check("c1_valid", rd_valid, 0);
    check("c1_addrb", ram_addrb, 0);
    tick();
    #1;
    check("c2_valid", rd_valid, 0);
    tick();
    #1;
    check("c3_valid", rd_valid, 1);
    check("c3_data", rd_data, 8'hA5);
    tick();
    #1;
    check("c4_valid", rd_valid, 0);
    tick();
    #1;
    check("c5_valid", rd_valid, 0);

    // Fill: 65 pushes (64 in RAM plus head), then drops
    rd_ready = 1'b0;
    for (int i = 0; i < 65; i++) begin
      tick();
      wr_en = 1'b1;
      wr_data = 8'(i);
      #1;
      if (i == 64) begin
        check("push65_full_before", full, 0);
        check("push65_we", ram_we, 1);
      end
    end
    tick();
    wr_en = 1'b1;
    wr_data = 8'h41;
    #1;
    check("fill_full", full, 1);
    check("fill_valid", rd_valid, 1);
    check("fill_head", rd_data, 8'h00);
    check("drop1_we", ram_we, 0);
    check("fill_ovf0", overflow, 0);
`ifdef UART_FIFO_LEVEL_EN
    check("fill_level", level, 65);
`endif
    tick();
    wr_data = 8'h42;
    ovf_clr = 1'b1;
    #1;
    check("drop1_ovf", overflow, 1);
    check("drop2_we", ram_we, 0);
    tick();
    wr_en = 1'b0;
    #1;
    check("ovf_set_wins", overflow, 1);
    tick();
    ovf_clr = 1'b0;
    #1;
    check("ovf_cleared", overflow, 0);

    // Drain 65 entries, one every 2 cycles
    tick();
    rd_ready = 1'b1;
    #1;
    n = 0;
    prev = 0;
    for (int c = 0; c < 300 && n < 65; c++) begin
      if (rd_valid) begin
        check("drain_data", rd_data, 32'(n));
        if (n > 0) check("drain_gap", c - prev, 2);
        prev = c;
        n++;
      end
      if (c == 1) check("full_after_fetch", full, 0);
      tick();
    end
    check("drain_count", n, 65);
    check("drain_empty", rd_valid, 0);

    // 200 interleaved pushes/pops across pointer wrap
    q.delete();
    pushed = 0;
    popped = 0;
`ifdef UART_FIFO_LEVEL_EN
    maxlvl = 0;
`endif
    for (int c = 0; c < 2000 && popped < 200; c++) begin
      wr_en = (c % 2 == 0) && (pushed < 200);
      wr_data = 8'(pushed * 37 + 11);
      rd_ready = (c % 5 != 0);
      #1;
      if (rd_valid && rd_ready) begin
        if (q.size() == 0) begin
          check("sb_underflow", rd_valid, 0);
        end else begin
          exp_b = q.pop_front();
          check("mix_data", rd_data, exp_b);
        end
        popped++;
      end
      if (wr_en) begin
        q.push_back(wr_data);
        pushed++;
      end
`ifdef UART_FIFO_LEVEL_EN
      if (32'(level) > maxlvl) maxlvl = 32'(level);
`endif
      tick();
    end
    wr_en = 1'b0;
    rd_ready = 1'b0;
    check("mix_popped", popped, 200);
    check("mix_left", q.size(), 0);
    check("mix_ovf", overflow, 0);
`ifdef UART_FIFO_LEVEL_EN
    check("mix_lvl_max", maxlvl <= 65, 1);
`endif

    // Reset with 10 entries and a fetch in flight
    tick();
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h10 + i);
      tick();
    end
    wr_en = 1'b0;
    tick();
    tick();
    #1;
    check("pre_rst_valid", rd_valid, 1);
    check("pre_rst_data", rd_data, 8'h10);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    #1;
    check("load_valid", rd_valid, 0);
`ifdef UART_FIFO_LEVEL_EN
    check("load_level", level, 9);
`endif
    rst = 1'b1;
    #1;
    check("arst_valid", rd_valid, 0);
    check("arst_full", full, 0);
    check("arst_ovf", overflow, 0);
    check("arst_data", rd_data, 0);
`ifdef UART_FIFO_LEVEL_EN
    check("arst_level", level, 0);
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();
    wr_en = 1'b1;
    wr_data = 8'h5A;
    rd_ready = 1'b1;
    tick();
    wr_en = 1'b0;
    tick();
    tick();
    #1;
    check("post_rst_valid", rd_valid, 1);
    check("post_rst_data", rd_data, 8'h5A);
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (rd_valid) extra++;
    end
    check("post_rst_only", extra, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
